// File: rtl/io_seq_pkg.sv
// Shared definitions for the I/O sequencer: FSM state encoding and a
// small decode helper used by the controller.
package io_seq_pkg;

    localparam logic [1:0] ENC_RUN     = 2'd0;
    localparam logic [1:0] ENC_WAIT_IN = 2'd1;
    localparam logic [1:0] ENC_COMMIT  = 2'd2;
    localparam logic [1:0] ENC_STOP    = 2'd3;

    typedef enum logic [1:0] {
        RUN     = ENC_RUN,
        WAIT_IN = ENC_WAIT_IN,
        COMMIT  = ENC_COMMIT,
        STOP    = ENC_STOP
    } state_t;

    // True when the decoded instruction is an IN (input) instruction.
    function automatic logic is_in_instr(input logic io_valid, input logic io_is_input);
        return io_valid & io_is_input;
    endfunction

endpackage

// File: rtl/io_sequencer_set_conditioner.sv
// Conditions the raw Set pushbutton: two-flop synchronizer, optional
// debounce (enabled with the SET_DEBOUNCE_EN macro) and a rising-edge
// detector that yields a single-cycle set_pulse per press.
module set_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic set_raw,
    output logic set_pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic level;
    logic level_prev_reg;

    // Two-flop synchronizer for the asynchronous pushbutton.
    always_ff @(posedge clk) begin
        if (srst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= set_raw;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef SET_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             deb_reg;

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive samples
    // disagreeing with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
            deb_reg <= 1'b0;
        end else if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign level = deb_reg;
`else
    assign level = sync2_reg;
`endif

    // Remember the previous conditioned level for edge detection.
    always_ff @(posedge clk) begin
        if (srst) begin
            level_prev_reg <= 1'b0;
        end else begin
            level_prev_reg <= level;
        end
    end

    assign set_pulse = level & ~level_prev_reg;

endmodule

// File: rtl/io_sequencer.sv
// I/O and halt controller: stalls the PC while an IN waits for Set,
// captures the switches, releases the core for one commit cycle, latches
// OUT operands and holds the core after HALT until Reset.
// Optional macro: SET_DEBOUNCE_EN (debounce on the Set pushbutton).
module io_sequencer
    import io_seq_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int IN_WIDTH        = 13,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Set,
    input  logic [IN_WIDTH-1:0]   Switches,
    input  logic                  HaltInstr,
    input  logic                  IoValid,
    input  logic                  IoIsInput,
    input  logic [DATA_WIDTH-1:0] OutData,
    output logic                  Halt,
    output logic [DATA_WIDTH-1:0] InData,
    output logic [DATA_WIDTH-1:0] OutLatch,
    output logic                  OutValid,
    output logic                  WaitingInput,
    output logic                  Stopped
);

    state_t                state_reg;
    state_t                state_next;
    logic                  set_pulse;
    logic                  capture_in;
    logic                  load_out;
    logic                  halt_next;
    logic [DATA_WIDTH-1:0] in_data_reg;
    logic [DATA_WIDTH-1:0] out_latch_reg;
    logic                  out_valid_reg;

    set_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_set_conditioner (
        .clk      (Clock),
        .srst     (Reset),
        .set_raw  (Set),
        .set_pulse(set_pulse)
    );

    // Next-state, stall and latch-enable decode; the decoding cycle of IN
    // and HALT is stalled immediately so the PC never advances past them.
    always_comb begin
        state_next = state_reg;
        halt_next  = 1'b0;
        capture_in = 1'b0;
        load_out   = 1'b0;
        unique case (state_reg)
            RUN: begin
                if (HaltInstr) begin
                    state_next = STOP;
                    halt_next  = 1'b1;
                end else if (is_in_instr(IoValid, IoIsInput)) begin
                    state_next = WAIT_IN;
                    halt_next  = 1'b1;
                end else if (IoValid) begin
                    load_out = 1'b1;
                end
            end
            WAIT_IN: begin
                halt_next = 1'b1;
                if (set_pulse) begin
                    capture_in = 1'b1;
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = RUN;
            end
            STOP: begin
                halt_next = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State register and data latches.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= RUN;
            in_data_reg   <= '0;
            out_latch_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_valid_reg <= load_out;
            if (capture_in) begin
                in_data_reg <= {{(DATA_WIDTH-IN_WIDTH){1'b0}}, Switches};
            end
            if (load_out) begin
                out_latch_reg <= OutData;
            end
        end
    end

    assign Halt         = halt_next;
    assign InData       = in_data_reg;
    assign OutLatch     = out_latch_reg;
    assign OutValid     = out_valid_reg;
    assign WaitingInput = (state_reg == WAIT_IN);
    assign Stopped      = (state_reg == STOP);

endmodule
